// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_multi_ch_if.sv
// Control/status bundle between register logic and the PWM generator.
interface pwm_multi_ch_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
);

  logic                      en;
  logic                      mode;
  logic [WIDTH-1:0]          period;
  logic [CHANNELS*WIDTH-1:0] duty;
  logic                      load;
  logic [CHANNELS-1:0]       pwm_out;
  logic [WIDTH-1:0]          cnt;
  logic                      period_end;
  logic                      load_ack;

  modport master (
    output en, mode, period, duty, load,
    input  pwm_out, cnt, period_end, load_ack
  );

  modport slave (
    input  en, mode, period, duty, load,
    output pwm_out, cnt, period_end, load_ack
  );

endinterface

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: up or up/down counter, boundary detect, and
// shadow/active period+mode with deferred transfer at the boundary.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_period,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_period_end,
  output logic             o_load_ack,
  output logic [WIDTH-1:0] o_cnt_nxt_c,
  output logic             o_xfer_c
);

  logic [WIDTH-1:0] r_cnt;
  dir_e             r_dir;
  logic             r_mode_act;
  logic             r_mode_sh;
  logic [WIDTH-1:0] r_period_act;
  logic [WIDTH-1:0] r_period_sh;
  logic             r_pending;
  logic             r_period_end;
  logic             r_load_ack;

  logic [WIDTH-1:0] w_cnt_nxt;
  dir_e             w_dir_nxt;
  logic             w_bnd;
  logic             w_xfer;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_dir        <= DIR_UP;
      r_mode_act   <= MODE_EDGE;
      r_mode_sh    <= MODE_EDGE;
      r_period_act <= '0;
      r_period_sh  <= '0;
      r_pending    <= 1'b0;
      r_period_end <= 1'b0;
      r_load_ack   <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_dir        <= w_dir_nxt;
      r_period_end <= w_bnd;
      r_load_ack   <= w_xfer;
      if (w_xfer) begin
        r_mode_act   <= r_mode_sh;
        r_period_act <= r_period_sh;
      end
      // A load on the transfer edge refills the shadow and stays pending.
      if (i_load) begin
        r_mode_sh   <= i_mode;
        r_period_sh <= i_period;
        r_pending   <= 1'b1;
      end else if (w_xfer) begin
        r_pending   <= 1'b0;
      end
    end
  end

  // Next count, direction and boundary
  always_comb begin
    w_cnt_nxt = '0;
    w_dir_nxt = DIR_UP;
    w_bnd     = 1'b0;
    if (i_en) begin
      if (r_period_act == '0) begin
        w_bnd = 1'b1;
      end else if (r_mode_act == MODE_EDGE) begin
        if (r_cnt >= r_period_act) begin
          w_bnd = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + WIDTH'(1);
        end
      end else if (r_dir == DIR_UP) begin
        w_cnt_nxt = r_cnt + WIDTH'(1);
        w_dir_nxt = (w_cnt_nxt >= r_period_act) ? DIR_DOWN : DIR_UP;
      end else begin
        w_cnt_nxt = r_cnt - WIDTH'(1);
        w_bnd     = (w_cnt_nxt == '0);
        w_dir_nxt = w_bnd ? DIR_UP : DIR_DOWN;
      end
    end
    // While disabled a pending shadow drains on the next edge.
    w_xfer = r_pending & (~i_en | w_bnd);
    if (w_xfer) begin
      w_dir_nxt = DIR_UP;
    end
  end

  assign o_cnt        = r_cnt;
  assign o_period_end = r_period_end;
  assign o_load_ack   = r_load_ack;
  assign o_cnt_nxt_c  = w_cnt_nxt;
  assign o_xfer_c     = w_xfer;

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shared timebase plus per-channel shadowed duty
// comparators, outputs registered from next-state count and duty.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
) (
  input  logic          clk,
  input  logic          rst,
  pwm_multi_ch_if.slave bus
);

  logic [WIDTH-1:0]    w_cnt;
  logic [WIDTH-1:0]    w_cnt_nxt;
  logic                w_period_end;
  logic                w_load_ack;
  logic                w_xfer;
  logic [CHANNELS-1:0] w_pwm_nxt;
  logic [CHANNELS-1:0] r_pwm;

  pwm_timebase #(
    .WIDTH (WIDTH)
  ) u_timebase (
    .clk          (clk),
    .rst          (rst),
    .i_en         (bus.en),
    .i_load       (bus.load),
    .i_mode       (bus.mode),
    .i_period     (bus.period),
    .o_cnt        (w_cnt),
    .o_period_end (w_period_end),
    .o_load_ack   (w_load_ack),
    .o_cnt_nxt_c  (w_cnt_nxt),
    .o_xfer_c     (w_xfer)
  );

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [WIDTH-1:0] r_duty_sh;
    logic [WIDTH-1:0] r_duty_act;
    logic [WIDTH-1:0] w_duty_nxt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_duty_sh  <= '0;
        r_duty_act <= '0;
      end else begin
        if (w_xfer) begin
          r_duty_act <= r_duty_sh;
        end
        if (bus.load) begin
          r_duty_sh <= bus.duty[gi*WIDTH +: WIDTH];
        end
      end
    end

    // Compare against the duty that will be active in the next cycle.
    assign w_duty_nxt    = w_xfer ? r_duty_sh : r_duty_act;
    assign w_pwm_nxt[gi] = bus.en & (w_cnt_nxt < w_duty_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= w_pwm_nxt;
    end
  end

  assign bus.pwm_out    = r_pwm;
  assign bus.cnt        = w_cnt;
  assign bus.period_end = w_period_end;
  assign bus.load_ack   = w_load_ack;

endmodule
